tmds_encoder_dvi: RTL and testbench

- One TMDS channel encoder: converts 8-bit pixel data or 2-bit control into a 10-bit DVI 1.0 TMDS symbol, tracking running DC disparity.
- Sits directly downstream of the colour/sync logic; dvi_generator instantiates three of these (blue/ch0 carries {vsync,hsync}; green/ch1 and red/ch2 carry ctrl 2'b00) and feeds their symbols to the 10:1 serializers.
- Fully registered; one symbol per clk_pix cycle.

---
 rtl/tmds_encoder_dvi_if.sv | 29 ++
 rtl/tmds_encoder_dvi.sv | 128 ++++++++++++
 tb/tb_tmds_encoder_dvi.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/tmds_encoder_dvi_if.sv
// Pixel-side bundle of one TMDS channel encoder: the selection and payload
// going in, plus the encoded symbol and running disparity coming out.
interface tmds_encoder_dvi_if #(
    parameter int DISPW = 5
);
    logic                    de;
    logic [7:0]              data_in;
    logic [1:0]              ctrl_in;
    logic [9:0]              tmds;
    logic signed [DISPW-1:0] disparity;

    // Colour/sync logic side: drives the pixel stream, observes symbols.
    modport master (
        output de,
        output data_in,
        output ctrl_in,
        input  tmds,
        input  disparity
    );

    // Encoder side.
    modport slave (
        input  de,
        input  data_in,
        input  ctrl_in,
        output tmds,
        output disparity
    );
endinterface

// File: rtl/tmds_encoder_dvi.sv
// DVI 1.0 TMDS encoder for a single channel. Each pixel clock it turns either
// an 8-bit colour component (de=1) or a 2-bit control code (de=0) into a
// 10-bit symbol, keeping a signed running disparity so the serial line stays
// DC balanced. One registered stage: inputs at edge N show up after edge N.
module tmds_encoder_dvi #(
    parameter int DISPW = 5
) (
    input  logic             clk_pix,
    input  logic             rst,
    tmds_encoder_dvi_if.slave bus
);

    // Disparity arithmetic runs two bits wider than the stored counter so a
    // result that would not fit DISPW bits is still visible to the overflow check.
    localparam int CW      = DISPW + 2;
    localparam int CNT_MAX = (2 ** (DISPW - 1)) - 1;
    localparam int CNT_MIN = -(2 ** (DISPW - 1));

    localparam logic signed [CW-1:0] TWO   = CW'(2);
    localparam logic signed [CW-1:0] EIGHT = CW'(8);

    localparam logic [9:0] SYM_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] SYM_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] SYM_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] SYM_CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimised word: bit 8 records XOR (1) versus XNOR (0) chaining.
    function automatic logic [8:0] minimise(input logic [7:0] v);
        logic [8:0] q;
        logic [3:0] n;
        logic       use_xnor;
        n        = ones8(v);
        use_xnor = (n > 4'd4) || ((n == 4'd4) && !v[0]);
        q[0]     = v[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ v[i]) : (q[i-1] ^ v[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = SYM_CTRL_00;
            2'b01:   s = SYM_CTRL_01;
            2'b10:   s = SYM_CTRL_10;
            default: s = SYM_CTRL_11;
        endcase
        return s;
    endfunction

    logic [8:0]             q_m_p0;
    logic [3:0]             n1_p0;
    logic signed [CW-1:0]   d_p0;
    logic signed [CW-1:0]   cnt_p0;
    logic signed [CW-1:0]   cnt_next_p0;
    logic signed [CW-1:0]   qm8_two_p0;
    logic signed [CW-1:0]   nqm8_two_p0;
    logic                   cnt_pos_p0;
    logic                   cnt_neg_p0;
    logic                   d_pos_p0;
    logic                   d_neg_p0;
    logic [9:0]             sym_p0;

    logic [9:0]             tmds_p1;
    logic signed [DISPW-1:0] disp_p1;

    // ---- stage p0: minimise transitions, then pick the DC-balance case ----
    always_comb begin
        q_m_p0      = minimise(bus.data_in);
        n1_p0       = ones8(q_m_p0[7:0]);
        // d = n1 - n0 = 2*n1 - 8
        d_p0        = $signed({{(CW-5){1'b0}}, n1_p0, 1'b0}) - EIGHT;
        cnt_p0      = {{2{disp_p1[DISPW-1]}}, disp_p1};
        qm8_two_p0  = q_m_p0[8] ? TWO : '0;
        nqm8_two_p0 = q_m_p0[8] ? '0 : TWO;
        cnt_pos_p0  = !cnt_p0[CW-1] && (cnt_p0 != '0);
        cnt_neg_p0  = cnt_p0[CW-1];
        d_pos_p0    = !d_p0[CW-1] && (d_p0 != '0);
        d_neg_p0    = d_p0[CW-1];
        sym_p0      = '0;
        cnt_next_p0 = cnt_p0;
        if ((cnt_p0 == '0) || (d_p0 == '0)) begin
            sym_p0      = {~q_m_p0[8], q_m_p0[8], q_m_p0[8] ? q_m_p0[7:0] : ~q_m_p0[7:0]};
            cnt_next_p0 = q_m_p0[8] ? (cnt_p0 + d_p0) : (cnt_p0 - d_p0);
        end else if ((cnt_pos_p0 && d_pos_p0) || (cnt_neg_p0 && d_neg_p0)) begin
            // Same sign as the running disparity: invert to pull back toward zero.
            sym_p0      = {1'b1, q_m_p0[8], ~q_m_p0[7:0]};
            cnt_next_p0 = cnt_p0 + qm8_two_p0 - d_p0;
        end else begin
            sym_p0      = {1'b0, q_m_p0[8], q_m_p0[7:0]};
            cnt_next_p0 = cnt_p0 + d_p0 - nqm8_two_p0;
        end
    end

    // ---- stage p1: register symbol and disparity; control periods clear disparity ----
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            tmds_p1 <= SYM_CTRL_00;
            disp_p1 <= '0;
        end else if (bus.de) begin
            tmds_p1 <= sym_p0;
            disp_p1 <= cnt_next_p0[DISPW-1:0];
        end else begin
            tmds_p1 <= ctrl_symbol(bus.ctrl_in);
            disp_p1 <= '0;
        end
    end

    assign bus.tmds      = tmds_p1;
    assign bus.disparity = disp_p1;

    // The balance algorithm keeps |disparity| <= 10; not fitting DISPW bits is a design error.
    a_disparity_fits : assert property (@(posedge clk_pix) disable iff (rst)
        !bus.de || ((int'(cnt_next_p0) <= CNT_MAX) && (int'(cnt_next_p0) >= CNT_MIN)))
        else $error("tmds_encoder_dvi: running disparity overflow");

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Bench for tmds_encoder_dvi: a driver issues symbols and queues the expected
// response; a monitor pops and checks each symbol one cycle later.
module tb_tmds_encoder_dvi;

    localparam int DISPW = 5;

    logic clk_pix;
    logic rst;

    tmds_encoder_dvi_if #(.DISPW(DISPW)) bus ();

    tmds_encoder_dvi #(.DISPW(DISPW)) dut (
        .clk_pix (clk_pix),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    typedef struct {
        bit [9:0] sym;
        int       disp;
        bit       is_data;
        bit [7:0] data;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    int n_pass  = 0;
    int n_total = 0;
    bit issued  = 1'b0;
    int model_cnt = 0;

    task automatic chk(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got 0x%0h (%0d) want 0x%0h (%0d)", name, got, got, want, want);
    endtask

    // Behavioural DVI 1.0 reference, written on plain integers.
    task automatic model_step(input bit d_e, input bit [7:0] d, input bit [1:0] c,
                              output bit [9:0] sym);
        int n1d, n1, n0, qm8;
        bit use_xnor;
        bit [8:0] qm;
        if (!d_e) begin
            case (c)
                2'b00: sym = 10'b1101010100;
                2'b01: sym = 10'b0010101011;
                2'b10: sym = 10'b0101010100;
                default: sym = 10'b1010101011;
            endcase
            model_cnt = 0;
            return;
        end
        n1d = $countones(d);
        use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !use_xnor;
        qm8 = qm[8] ? 1 : 0;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (model_cnt == 0 || n1 == n0) begin
            sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            model_cnt = qm[8] ? model_cnt + (n1 - n0) : model_cnt + (n0 - n1);
        end else if ((model_cnt > 0 && n1 > n0) || (model_cnt < 0 && n0 > n1)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            model_cnt = model_cnt + 2 * qm8 - (n1 - n0);
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            model_cnt = model_cnt + (n1 - n0) - 2 * (1 - qm8);
        end
    endtask

    function automatic bit [7:0] decode(input bit [9:0] s);
        bit [7:0] q, o;
        q = s[9] ? ~s[7:0] : s[7:0];
        o[0] = q[0];
        for (int i = 1; i < 8; i++)
            o[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return o;
    endfunction

    // Drive one input set; the expectation is either the hand value or the model's.
    task automatic drive(input bit d_e, input bit [7:0] d, input bit [1:0] c,
                         input bit hand, input bit [9:0] hsym, input int hdisp,
                         input string tag);
        bit [9:0] msym;
        exp_t e;
        @(posedge clk_pix);
        #1;
        bus.de = d_e;
        if (d_e) begin
            bus.data_in = d;
            bus.ctrl_in = 'x;
        end else begin
            bus.data_in = 'x;
            bus.ctrl_in = c;
        end
        issued = 1'b1;
        model_step(d_e, d, c, msym);
        e.sym     = hand ? hsym : msym;
        e.disp    = hand ? hdisp : model_cnt;
        e.is_data = d_e;
        e.data    = d;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic idle();
        @(posedge clk_pix);
        #1;
        issued      = 1'b0;
        bus.de      = 1'b0;
        bus.ctrl_in = 2'b00;
        bus.data_in = 8'h00;
    endtask

    // Monitor: an input set accepted at a rising edge is checked on the following falling edge.
    initial begin
        bit   cap;
        exp_t e;
        string tag;
        int   got_d;
        forever begin
            @(posedge clk_pix);
            cap = issued && !rst;
            @(negedge clk_pix);
            if (cap) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL scoreboard_empty: got symbol 0x%0h want none", bus.tmds);
                end else begin
                    e   = exp_q.pop_front();
                    tag = tag_q.pop_front();
                    got_d = int'(bus.disparity);
                    chk({tag, "_sym"}, int'(bus.tmds), int'(e.sym));
                    chk({tag, "_disp"}, got_d, e.disp);
                    chk({tag, "_bound"}, ((got_d <= 10) && (got_d >= -10)) ? 1 : 0, 1);
                    if (e.is_data)
                        chk({tag, "_decode"}, int'(decode(bus.tmds)), int'(e.data));
                end
            end
        end
    end

    initial begin
        bit [7:0] rd;
        bit [1:0] rc;
        bit       rde;
        rst         = 1'b1;
        bus.de      = 1'b0;
        bus.data_in = 8'h00;
        bus.ctrl_in = 2'b00;
        #3;
        chk("reset_tmds", int'(bus.tmds), 32'h354);
        chk("reset_disp", int'(bus.disparity), 0);
        @(posedge clk_pix);
        #1;
        rst = 1'b0;

        // Control codes on consecutive cycles.
        drive(1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0, "ctrl00");
        drive(1'b0, 8'h00, 2'b01, 1'b1, 10'h0AB, 0, "ctrl01");
        drive(1'b0, 8'h00, 2'b10, 1'b1, 10'h154, 0, "ctrl10");
        drive(1'b0, 8'h00, 2'b11, 1'b1, 10'h2AB, 0, "ctrl11");

        // Three zero bytes from cnt=0 walk cases A, B, C.
        drive(1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8, "zero_a");
        drive(1'b1, 8'h00, 2'b00, 1'b1, 10'h3FF,  2, "zero_b");
        drive(1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -6, "zero_c");

        // All ones, then a control cycle clears disparity before the next data.
        drive(1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0, "ctrl_pre");
        drive(1'b1, 8'hFF, 2'b00, 1'b1, 10'h200, -8, "ones");
        drive(1'b0, 8'h00, 2'b01, 1'b1, 10'h0AB, 0, "ctrl_mid");
        drive(1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8, "after_ctrl");

        // Reset mid-stream while disparity is -8: output must clear without a clock edge.
        idle();
        @(negedge clk_pix);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tmds", int'(bus.tmds), 32'h354);
        chk("midrst_disp", int'(bus.disparity), 0);
        @(posedge clk_pix);
        #1;
        rst = 1'b0;
        model_cnt = 0;
        drive(1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0, "post_rst0");
        drive(1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0, "post_rst1");

        // One 1080p line: blanking with an hsync pulse, then 1920 random pixels.
        for (int i = 0; i < 2200; i++) begin
            rd  = 8'($urandom_range(0, 255));
            rde = (i >= 280);
            rc  = {1'b0, (i >= 88 && i < 132)};
            drive(rde, rd, rc, 1'b0, 10'h000, 0, rde ? "line_px" : "line_blank");
        end

        // Random de toggling.
        for (int i = 0; i < 200; i++) begin
            rd  = 8'($urandom_range(0, 255));
            rc  = 2'($urandom_range(0, 3));
            rde = ($urandom_range(0, 3) != 0);
            drive(rde, rd, rc, 1'b0, 10'h000, 0, "toggle");
        end

        // Every byte from starting disparity -8, 0 and +8.
        for (int v = 0; v < 256; v++) begin
            for (int s = 0; s < 3; s++) begin
                drive(1'b0, 8'h00, 2'b00, 1'b0, 10'h000, 0, "sweep_ctrl");
                if (s == 0) drive(1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8, "sweep_to_m8");
                if (s == 2) drive(1'b1, 8'h01, 2'b00, 1'b1, 10'h1FF,  8, "sweep_to_p8");
                drive(1'b1, 8'(v), 2'b00, 1'b0, 10'h000, 0, "sweep");
            end
        end

        idle();
        repeat (3) @(posedge clk_pix);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
